dmem_store: RTL and testbench

// - Store-side counterpart to the load-data decode path: turns a core store request into data-memory write beats.
// - Inputs per request: width, byte address, register data. Outputs per beat: word address, lane-shifted wdata, byte strobes.
// - Sits between execute (store request) and the data-memory write port.
// - A misaligned store is either split into two word beats or rejected, depending on DMEM_MISALIGNED_SPLIT_EN.

---
 rtl/dmem_store.sv | 196 +++++++++++++++++++
 tb/tb_dmem_store.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store.sv
// dmem_store: turns a core store request into lane-shifted data-memory write beats.
// Define DMEM_MISALIGNED_SPLIT_EN to split word-crossing stores into two beats instead of faulting them.
`timescale 1ns/1ps
module dmem_store (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_width,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_fault,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb
);

`ifdef DMEM_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, BEAT0 = 1'b1} state_t;
`endif

  state_t      state_q, state_d;
  logic        st_ready_q, st_ready_d;
  logic        st_done_q, st_done_d;
  logic        st_fault_q, st_fault_d;
  logic        dmem_valid_q, dmem_valid_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] data_m;
  logic [31:0] addr_aligned;
  logic [31:0] lo_wdata;
  logic [3:0]  lo_wstrb;
  logic        accept;
  logic        reject;
  logic        last_hs;

  assign off          = st_addr[1:0];
  assign addr_aligned = {st_addr[31:2], 2'b00};
  assign accept       = st_valid & st_ready_q;

  always_comb begin
    case (st_width)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // Zero the bytes outside the access width so unused lanes never carry stale register bits.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign data_m[8*gi +: 8] = st_data[8*gi +: 8] & {8{mask[gi]}};
  end

`ifdef DMEM_MISALIGNED_SPLIT_EN
  logic [63:0] d64;
  logic [7:0]  s8;
  logic [31:0] hi_wdata;
  logic [3:0]  hi_wstrb;
  logic [31:0] b1_wdata_q, b1_wdata_d;
  logic [3:0]  b1_wstrb_q, b1_wstrb_d;

  assign d64      = {32'b0, data_m} << {off, 3'b000};
  assign s8       = {4'b0, mask} << off;
  assign lo_wdata = d64[31:0];
  assign lo_wstrb = s8[3:0];
  assign hi_wdata = d64[63:32];
  assign hi_wstrb = s8[7:4];
  assign reject   = (st_width == 2'd3);
  // A zero second-beat strobe means the store fits in one word.
  assign last_hs  = dmem_valid_q & dmem_ready &
                    ((state_q == BEAT1) | ((state_q == BEAT0) & (b1_wstrb_q == 4'b0000)));
`else
  logic [31:0] d32;
  logic [3:0]  s4;
  logic        misaligned;

  assign d32        = data_m << {off, 3'b000};
  assign s4         = mask << off;
  assign lo_wdata   = d32;
  assign lo_wstrb   = s4;
  assign misaligned = ((st_width == 2'd1) & off[0]) | ((st_width == 2'd2) & (off != 2'b00));
  assign reject     = (st_width == 2'd3) | misaligned;
  assign last_hs    = dmem_valid_q & dmem_ready & (state_q == BEAT0);
`endif

  always_comb begin
    state_d      = state_q;
    st_ready_d   = st_ready_q;
    st_done_d    = 1'b0;
    st_fault_d   = 1'b0;
    dmem_valid_d = dmem_valid_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    b1_wdata_d   = b1_wdata_q;
    b1_wstrb_d   = b1_wstrb_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            st_fault_d = 1'b1;
          end else begin
            state_d      = BEAT0;
            st_ready_d   = 1'b0;
            dmem_valid_d = 1'b1;
            dmem_addr_d  = addr_aligned;
            dmem_wdata_d = lo_wdata;
            dmem_wstrb_d = lo_wstrb;
`ifdef DMEM_MISALIGNED_SPLIT_EN
            b1_wdata_d   = hi_wdata;
            b1_wstrb_d   = hi_wstrb;
`endif
          end
        end
      end
      BEAT0: begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
        // Address increment wraps naturally at the top of the address space.
        if (dmem_ready && (b1_wstrb_q != 4'b0000)) begin
          state_d      = BEAT1;
          dmem_addr_d  = dmem_addr_q + 32'd4;
          dmem_wdata_d = b1_wdata_q;
          dmem_wstrb_d = b1_wstrb_q;
        end
`endif
      end
`ifdef DMEM_MISALIGNED_SPLIT_EN
      BEAT1: begin
        state_d = BEAT1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (last_hs) begin
      state_d      = IDLE;
      dmem_valid_d = 1'b0;
      st_done_d    = 1'b1;
      st_ready_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      st_ready_q   <= 1'b1;
      st_done_q    <= 1'b0;
      st_fault_q   <= 1'b0;
      dmem_valid_q <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      b1_wdata_q   <= 32'd0;
      b1_wstrb_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      st_ready_q   <= st_ready_d;
      st_done_q    <= st_done_d;
      st_fault_q   <= st_fault_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      b1_wdata_q   <= b1_wdata_d;
      b1_wstrb_q   <= b1_wstrb_d;
`endif
    end
  end

  assign st_ready   = st_ready_q;
  assign st_done    = st_done_q;
  assign st_fault   = st_fault_q;
  assign dmem_valid = dmem_valid_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;

  a_done_fault_excl: assert property (@(posedge clk) disable iff (rst) !(st_done_q && st_fault_q));
  a_addr_aligned:    assert property (@(posedge clk) disable iff (rst) dmem_addr_q[1:0] == 2'b00);

endmodule

// File: tb/tb_dmem_store.sv
// Bench for dmem_store: vector table, directed back-to-back/reset sequences, and random stores
// checked against a byte-by-byte reference model.
`timescale 1ns/1ps
module tb_dmem_store;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_width;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_fault;
  logic        dmem_valid;
  logic        dmem_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;

  always #5 clk = ~clk;

  dmem_store dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_width(st_width),
    .st_addr(st_addr), .st_data(st_data), .st_done(st_done), .st_fault(st_fault),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    int          stall;
    int          n;
    bit          flt;
    beat_t       b0;
    beat_t       b1;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  beat_t got_b [4];
  int    got_n;
  bit    got_done, got_fault;
  beat_t exp_b [4];
  int    exp_n;
  bit    exp_f;
  vec_t  vt [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t bt(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return {a, d, s};
  endfunction

  function automatic vec_t mkv(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                               input int stall, input int n, input bit flt, input beat_t b0, input beat_t b1);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.stall = stall; v.n = n; v.flt = flt; v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  // Reference: place each byte at its own address, grouping bytes by containing word.
  task automatic model(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    int          nbytes;
    int          lane;
    logic [31:0] ba;
    logic [31:0] wa;
    exp_n = 0;
    exp_f = 1'b0;
    for (int i = 0; i < 4; i++) exp_b[i] = '0;
    if (w == 2'd3) begin
      exp_f = 1'b1;
    end else begin
      nbytes = 1 << w;
`ifndef DMEM_MISALIGNED_SPLIT_EN
      if ((a[1:0] & 2'(nbytes - 1)) != 2'b00) exp_f = 1'b1;
`endif
      if (!exp_f) begin
        for (int i = 0; i < nbytes; i++) begin
          ba   = a + 32'(i);
          wa   = {ba[31:2], 2'b00};
          lane = int'(ba[1:0]);
          if (exp_n == 0 || exp_b[exp_n-1].addr != wa) exp_n++;
          exp_b[exp_n-1].addr              = wa;
          exp_b[exp_n-1].wstrb[lane]       = 1'b1;
          exp_b[exp_n-1].wdata[8*lane +: 8] = d[8*i +: 8];
        end
      end
    end
  endtask

  // stall<0: random 0..3 ready-low cycles per beat; otherwise that many per beat.
  task automatic do_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d, input int stall);
    beat_t cur;
    beat_t held;
    bit    held_v;
    int    wait_left;
    int    last_hs;
    held = '0; held_v = 1'b0; wait_left = 0; last_hs = -10;
    got_n = 0; got_done = 1'b0; got_fault = 1'b0;
    @(negedge clk);
    chk("ready_before", 128'(st_ready), 128'(1));
    st_valid = 1'b1; st_width = w; st_addr = a; st_data = d;
    @(negedge clk);
    st_valid = 1'b0; st_width = 2'($urandom); st_addr = $urandom; st_data = $urandom;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (st_done || st_fault) begin
        got_done = st_done; got_fault = st_fault;
        chk("end_ready", 128'(st_ready), 128'(1));
        chk("end_valid", 128'(dmem_valid), 128'(0));
        if (st_done) chk("done_latency", 128'(cyc - last_hs), 128'(1));
        else         chk("fault_latency", 128'(cyc), 128'(0));
        break;
      end
      if (dmem_valid) begin
        cur = {dmem_addr, dmem_wdata, dmem_wstrb};
        chk("busy_ready", 128'(st_ready), 128'(0));
        if (held_v) chk("stall_stable", 128'(cur), 128'(held));
        else wait_left = (stall < 0) ? int'($urandom_range(3)) : stall;
        if (wait_left > 0) begin
          dmem_ready = 1'b0; wait_left--; held = cur; held_v = 1'b1;
        end else begin
          dmem_ready = 1'b1; held_v = 1'b0;
          if (got_n < 4) got_b[got_n] = cur;
          got_n++;
          last_hs = cyc;
        end
      end else begin
        if (held_v) chk("beat_withdrawn", 128'(dmem_valid), 128'(1));
        held_v = 1'b0;
        dmem_ready = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("finished", 128'(got_done | got_fault), 128'(1));
    @(negedge clk);
    chk("pulse_one_cycle", 128'({st_done, st_fault}), 128'(0));
  endtask

  task automatic check_result(input int id, input logic [1:0] w, input logic [31:0] a);
    $display("txn %0d: w=%0d addr=%h beats=%0d done=%0b fault=%0b", id, w, a, got_n, got_done, got_fault);
    chk($sformatf("fault txn%0d", id), 128'(got_fault), 128'(exp_f));
    chk($sformatf("done txn%0d", id), 128'(got_done), 128'(!exp_f));
    chk($sformatf("nbeats txn%0d", id), 128'(got_n), 128'(exp_n));
    for (int i = 0; i < exp_n && i < got_n; i++)
      chk($sformatf("beat%0d txn%0d", i, id), 128'(got_b[i]), 128'(exp_b[i]));
  endtask

  initial begin
    vt[0] = mkv(2'd0, 32'h0000_1003, 32'h0000_00AB, 0, 1, 0, bt(32'h1000, 32'hAB00_0000, 4'b1000), '0);
    vt[1] = mkv(2'd1, 32'h0000_2002, 32'h1234_BEEF, 3, 1, 0, bt(32'h2000, 32'hBEEF_0000, 4'b1100), '0);
    vt[2] = mkv(2'd2, 32'h0000_3000, 32'h1122_3344, 1, 1, 0, bt(32'h3000, 32'h1122_3344, 4'b1111), '0);
    vt[3] = mkv(2'd3, 32'h0000_3000, 32'h0000_0055, 0, 0, 1, '0, '0);
    vt[4] = mkv(2'd0, 32'h0000_0010, 32'hFFFF_FF5A, 0, 1, 0, bt(32'h0010, 32'h0000_005A, 4'b0001), '0);
    vt[9] = mkv(2'd0, 32'hFFFF_FFFF, 32'h0000_0012, 2, 1, 0, bt(32'hFFFF_FFFC, 32'h1200_0000, 4'b1000), '0);
`ifdef DMEM_MISALIGNED_SPLIT_EN
    vt[5] = mkv(2'd1, 32'h0000_0021, 32'h1234_ABCD, 0, 1, 0, bt(32'h0020, 32'h00AB_CD00, 4'b0110), '0);
    vt[6] = mkv(2'd2, 32'h0000_3001, 32'h1122_3344, 0, 2, 0, bt(32'h3000, 32'h2233_4400, 4'b1110),
                bt(32'h3004, 32'h0000_0011, 4'b0001));
    vt[7] = mkv(2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1, 2, 0, bt(32'hFFFF_FFFC, 32'hF00D_0000, 4'b1100),
                bt(32'h0000_0000, 32'h0000_CAFE, 4'b0011));
    vt[8] = mkv(2'd1, 32'h0000_0103, 32'h0000_BEEF, 0, 2, 0, bt(32'h0100, 32'hEF00_0000, 4'b1000),
                bt(32'h0104, 32'h0000_00BE, 4'b0001));
`else
    vt[5] = mkv(2'd1, 32'h0000_0021, 32'h1234_ABCD, 0, 0, 1, '0, '0);
    vt[6] = mkv(2'd2, 32'h0000_3001, 32'h1122_3344, 0, 0, 1, '0, '0);
    vt[7] = mkv(2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0, 1, '0, '0);
    vt[8] = mkv(2'd1, 32'h0000_0103, 32'h0000_BEEF, 0, 0, 1, '0, '0);
`endif

    rst = 1'b1; st_valid = 1'b0; st_width = 2'd0; st_addr = '0; st_data = '0; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({st_ready, st_done, st_fault, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb}),
        128'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0}));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_store(vt[i].w, vt[i].a, vt[i].d, vt[i].stall);
      exp_n = vt[i].n; exp_f = vt[i].flt;
      exp_b[0] = vt[i].b0; exp_b[1] = vt[i].b1; exp_b[2] = '0; exp_b[3] = '0;
      check_result(i, vt[i].w, vt[i].a);
    end

    // Back-to-back: second request held valid is taken in the st_done cycle.
    @(negedge clk);
    st_valid = 1'b1; st_width = 2'd0; st_addr = 32'h0000_5001; st_data = 32'h0000_0077; dmem_ready = 1'b1;
    @(negedge clk);
    chk("b2b_first_beat", 128'({dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb}),
        128'({1'b1, 32'h5000, 32'h0000_7700, 4'b0010}));
    st_width = 2'd2; st_addr = 32'h0000_6000; st_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("b2b_first_done", 128'({st_done, st_ready, dmem_valid}), 128'(3'b110));
    @(negedge clk);
    st_valid = 1'b0;
    chk("b2b_second_beat", 128'({dmem_valid, st_done, dmem_addr, dmem_wdata, dmem_wstrb}),
        128'({1'b1, 1'b0, 32'h6000, 32'hDEAD_BEEF, 4'b1111}));
    @(negedge clk);
    chk("b2b_second_done", 128'(st_done), 128'(1));
    @(negedge clk);
    chk("b2b_done_pulse", 128'(st_done), 128'(0));
    $display("txn b2b: two stores back-to-back");

    // Reset while a beat is stalled: beat dropped, no completion.
    dmem_ready = 1'b0; st_valid = 1'b1; st_width = 2'd2; st_data = 32'h1122_3344;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    st_addr = 32'h0000_3001;
`else
    st_addr = 32'h0000_4000;
`endif
    @(negedge clk);
    st_valid = 1'b0;
    chk("rst_seq_busy", 128'(dmem_valid), 128'(1));
`ifdef DMEM_MISALIGNED_SPLIT_EN
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("rst_seq_beat1", 128'({dmem_valid, dmem_addr, dmem_wstrb}), 128'({1'b1, 32'h3004, 4'b0001}));
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_seq_outputs", 128'({st_ready, st_done, st_fault, dmem_valid, dmem_addr, dmem_wstrb}),
        128'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_seq_quiet", 128'({st_done, st_fault, dmem_valid}), 128'(0));
    end
    $display("txn rst: reset during stalled beat");

    for (int k = 0; k < 300; k++) begin
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      w = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(3));
      else                        a = $urandom;
      d = $urandom;
      do_store(w, a, d, -1);
      model(w, a, d);
      check_result(100 + k, w, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
